// File: rtl/ula_pkg.sv
// Shared constants and types for the ULA CPU-side write front end.
package ula_pkg;

  // An I/O access selects a port when (cpu_addr & mask) == 0.
  localparam logic [15:0] PORT_FE   = 16'h0001;
  localparam logic [15:0] PORT_7FFD = 16'h8002;

  localparam int P7FFD_LOCK   = 5;
  localparam int P7FFD_SHADOW = 3;
  localparam int P7FFD_HIRES  = 6;

  localparam logic [12:0] SCREEN_TOP = 13'h1AFF;

  typedef struct packed {
    logic        bank;
    logic [12:0] offset;
    logic [7:0]  data;
  } vram_entry_t;

endpackage

// File: rtl/ula_wfifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module ula_wfifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ula_bus.sv
// Z80 write front end: decodes port FE / 7FFD writes and queues screen-area
// memory writes toward the screen RAM write port.
module ula_bus
  import ula_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [12:0] SCREEN_TOP = ula_pkg::SCREEN_TOP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mwr,
  input  logic        cpu_iowr,
  output logic [7:0]  port7ffd,
  output logic [2:0]  border,
  output logic        vram_we,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_data,
  input  logic        vram_busy,
  output logic        fifo_full,
  output logic        overflow
);

  logic        io_fe;
  logic        io_7ffd;
  logic [2:0]  page;
  logic        page_hit;
  logic        screen_wr;
  logic        fifo_empty;
  logic        pop;
  vram_entry_t push_entry;
  vram_entry_t head;

  assign io_fe   = cpu_iowr && ((cpu_addr & PORT_FE) == 16'h0000);
  assign io_7ffd = cpu_iowr && ((cpu_addr & PORT_7FFD) == 16'h0000);

  always_ff @(posedge clock) begin
    if (reset) begin
      port7ffd <= '0;
      border   <= '0;
    end else begin
      if (io_fe) border <= cpu_dout[2:0];
      if (io_7ffd && !port7ffd[P7FFD_LOCK]) port7ffd <= cpu_dout;
    end
  end

  // Uses the pre-edge port7ffd, so a same-cycle I/O write cannot remap this access.
  always_comb begin
    page     = 3'd0;
    page_hit = 1'b0;
    case (cpu_addr[15:14])
      2'b01: begin
        page     = 3'd5;
        page_hit = 1'b1;
      end
      2'b11: begin
        page     = port7ffd[2:0];
        page_hit = 1'b1;
      end
      default: begin
        page     = 3'd0;
        page_hit = 1'b0;
      end
    endcase
  end

  assign screen_wr = cpu_mwr && page_hit && ((page == 3'd5) || (page == 3'd7)) &&
                     (cpu_addr[13:0] <= {1'b0, SCREEN_TOP});

  assign push_entry.bank   = (page == 3'd7);
  assign push_entry.offset = cpu_addr[12:0];
  assign push_entry.data   = cpu_dout;

  // vram_we is the valid, !vram_busy the ready; a word transfers on a cycle
  // where both hold, and the head stays stable until then.
  assign vram_we   = !fifo_empty;
  assign pop       = vram_we && !vram_busy;
  assign vram_addr = {head.bank, head.offset};
  assign vram_data = head.data;

  ula_wfifo #(
    .WIDTH ($bits(vram_entry_t)),
    .DEPTH (DEPTH)
  ) u_wfifo (
    .clock (clock),
    .reset (reset),
    .push  (screen_wr),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (screen_wr && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ula_bus.sv
// Directed bench for ula_bus: register decode checks plus a scoreboard that
// matches every RAM write against an expected queue.
module tb_ula_bus;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mwr;
  logic        cpu_iowr;
  logic [7:0]  port7ffd;
  logic [2:0]  border;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_busy;
  logic        fifo_full;
  logic        overflow;

  logic [21:0] exp_q[$];
  int          pass_cnt;
  int          check_cnt;
  int          wr_cnt;
  int          wr_start;

  ula_bus #(.DEPTH(4), .SCREEN_TOP(13'h1AFF)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_mwr   (cpu_mwr),
    .cpu_iowr  (cpu_iowr),
    .port7ffd  (port7ffd),
    .border    (border),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .vram_busy (vram_busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #20 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
  endtask

  // Driver tasks
  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_iowr = 1'b1;
    tick();
    cpu_iowr = 1'b0;
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d,
                           input bit exp_push, input logic [21:0] exp_e);
    cpu_addr = a;
    cpu_dout = d;
    cpu_mwr  = 1'b1;
    if (exp_push) exp_q.push_back(exp_e);
    tick();
    cpu_mwr = 1'b0;
  endtask

  // Scoreboard monitor: every completed transfer must match the queue head.
  always @(negedge clock) begin
    if (vram_we === 1'b1 && vram_busy === 1'b0) begin
      logic [21:0] e;
      wr_cnt++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL vram_write_unexpected: act=0x%0h req=none", {vram_addr, vram_data});
      end else begin
        e = exp_q.pop_front();
        if ({vram_addr, vram_data} === e) pass_cnt++;
        else $display("FAIL vram_write: act=0x%0h req=0x%0h", {vram_addr, vram_data}, e);
      end
    end
  end

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    wr_cnt    = 0;
    reset     = 1'b1;
    cpu_addr  = '0;
    cpu_dout  = '0;
    cpu_mwr   = 1'b0;
    cpu_iowr  = 1'b0;
    vram_busy = 1'b0;
    do_reset();

    chk("rst_port7ffd", 32'(port7ffd), 32'h00);
    chk("rst_border", 32'(border), 32'h0);
    chk("rst_vram_we", 32'(vram_we), 32'h0);
    chk("rst_fifo_full", 32'(fifo_full), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);

    // I/O decode and lock
    io_write(16'h7FFD, 8'h17);
    chk("p7ffd_17", 32'(port7ffd), 32'h17);
    io_write(16'h00FE, 8'h05);
    chk("border_5", 32'(border), 32'h5);
    chk("p7ffd_kept", 32'(port7ffd), 32'h17);
    io_write(16'h7FFD, 8'h20);
    chk("p7ffd_20", 32'(port7ffd), 32'h20);
    io_write(16'h7FFD, 8'h07);
    chk("p7ffd_locked", 32'(port7ffd), 32'h20);
    io_write(16'h00FC, 8'h02);
    chk("both_ports_border", 32'(border), 32'h2);
    do_reset();
    io_write(16'h00FC, 8'h13);
    chk("both_ports_p7ffd", 32'(port7ffd), 32'h13);
    chk("both_ports_border2", 32'(border), 32'h3);
    do_reset();

    // Single page-5 write, one-cycle request
    mem_write(16'h4000, 8'hAA, 1'b1, {1'b0, 13'h0000, 8'hAA});
    chk("single_we", 32'(vram_we), 32'h1);
    chk("single_addr", 32'(vram_addr), 32'h0000);
    chk("single_data", 32'(vram_data), 32'hAA);
    tick();
    chk("single_we_drop", 32'(vram_we), 32'h0);
    mem_write(16'h5B00, 8'h11, 1'b0, '0);
    chk("above_top_we", 32'(vram_we), 32'h0);
    tick();
    chk("above_top_we2", 32'(vram_we), 32'h0);

    // Upper-bank page mapping
    io_write(16'h7FFD, 8'h07);
    mem_write(16'hDAFF, 8'h3C, 1'b1, {1'b1, 13'h1AFF, 8'h3C});
    chk("page7_addr", 32'(vram_addr), 32'h3AFF);
    tick();
    io_write(16'h7FFD, 8'h05);
    mem_write(16'hC010, 8'h5A, 1'b1, {1'b0, 13'h0010, 8'h5A});
    chk("page5_alias_addr", 32'(vram_addr), 32'h0010);
    tick();
    io_write(16'h7FFD, 8'h03);
    mem_write(16'hC010, 8'h66, 1'b0, '0);
    chk("page3_drop", 32'(vram_we), 32'h0);
    mem_write(16'h8010, 8'h67, 1'b0, '0);
    chk("page2_drop", 32'(vram_we), 32'h0);
    tick();
    chk("drain1_empty", 32'(exp_q.size()), 32'h0);

    // Fill while stalled, then overflow
    do_reset();
    vram_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_write(16'h4000 + 16'(i), 8'h10 + 8'(i), (i < 4), {1'b0, 13'(i), 8'h10 + 8'(i)});
      if (i == 2) chk("fill3_full", 32'(fifo_full), 32'h0);
      if (i == 3) begin
        chk("fill4_full", 32'(fifo_full), 32'h1);
        chk("fill4_overflow", 32'(overflow), 32'h0);
      end
    end
    chk("fill5_overflow", 32'(overflow), 32'h1);
    chk("fill5_full", 32'(fifo_full), 32'h1);
    wr_start  = wr_cnt;
    vram_busy = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("overflow_drain_cnt", 32'(wr_cnt - wr_start), 32'd4);
    chk("overflow_drain_q", 32'(exp_q.size()), 32'h0);
    chk("overflow_sticky", 32'(overflow), 32'h1);
    chk("overflow_drain_we", 32'(vram_we), 32'h0);

    // Full with simultaneous push and pop
    do_reset();
    wr_start  = wr_cnt;
    vram_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      mem_write(16'h4100 + 16'(i), 8'hA0 + 8'(i), 1'b1, {1'b0, 13'h0100 + 13'(i), 8'hA0 + 8'(i)});
    vram_busy = 1'b0;
    mem_write(16'h4104, 8'hA4, 1'b1, {1'b0, 13'h0104, 8'hA4});
    chk("pushpop_full", 32'(fifo_full), 32'h1);
    chk("pushpop_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("pushpop_drain_cnt", 32'(wr_cnt - wr_start), 32'd5);
    chk("pushpop_drain_q", 32'(exp_q.size()), 32'h0);

    // Reset with entries queued
    vram_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      mem_write(16'h4200 + 16'(i), 8'hC0 + 8'(i), 1'b1, {1'b0, 13'h0200 + 13'(i), 8'hC0 + 8'(i)});
    chk("preflush_we", 32'(vram_we), 32'h1);
    wr_start = wr_cnt;
    reset    = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("flush_we", 32'(vram_we), 32'h0);
    vram_busy = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("flush_no_writes", 32'(wr_cnt - wr_start), 32'd0);
    chk("flush_full", 32'(fifo_full), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/ula_bus.md
# ula_bus

CPU-side write front end for the ULA video subsystem. It decodes Z80 I/O writes into the `port7ffd` and `border` registers the video generator consumes. It snoops Z80 memory writes, filters those that land in the two Spectrum screen areas (page 5 and shadow page 7, offsets 0x0000–0x1AFF), and queues them in a 4-entry FIFO. The FIFO drains into the write port of the dual-port screen RAM, whose read port is owned by the ULA.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥2.
- `SCREEN_TOP`, 13'h1AFF: last in-page screen offset (pixels plus attributes).

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, 25 MHz
- `reset`  in  1  synchronous, active-high reset
- `cpu_addr`  in  16  Z80 address bus
- `cpu_dout`  in  8  Z80 write data
- `cpu_mwr`  in  1  one-cycle pulse: memory write
- `cpu_iowr`  in  1  one-cycle pulse: I/O write
- `port7ffd`  out  8  paging/video register to the ULA
- `border`  out  3  border colour to the ULA
- `vram_we`  out  1  write request; high while the FIFO is not empty
- `vram_addr`  out  14  bit 13 = bank (0 = page 5, 1 = page 7); bits 12:0 = offset
- `vram_data`  out  8  write data
- `vram_busy`  in  1  RAM port stall; a transfer completes on a cycle with `vram_we && !vram_busy`
- `fifo_full`  out  1  occupancy == `DEPTH`
- `overflow`  out  1  sticky: a screen write was dropped

## Operation
I/O decode, evaluated on `cpu_iowr`:
- **Port FE** (`cpu_addr[0]==0`): `border <= cpu_dout[2:0]`.
- **Port 7FFD** (`cpu_addr[15]==0 && cpu_addr[1]==0`):
  - If `port7ffd[5]==0`: `port7ffd <= cpu_dout`.
  - If `port7ffd[5]==1` (locked): ignored until reset.
- One access can match both ports. Both updates then apply.

Memory write filter, evaluated on `cpu_mwr`:
- Page selection:
  - 0x4000–0x7FFF is page 5.
  - 0xC000–0xFFFF is page `port7ffd[2:0]`.
  - All other addresses are discarded.
- A write is a screen write when the page is 5 or 7 and `cpu_addr[13:0] <= SCREEN_TOP`.
- Entry pushed: `{bank, cpu_addr[12:0], cpu_dout}`, where `bank = (page==7)`.
- Page 7 mapped at 0xC000 and page 5 at 0x4000 are both valid aliases.

FIFO:
- Head entry drives `vram_addr` and `vram_data` combinationally. `vram_we = !empty`.
- Pop on `vram_we && !vram_busy`.
- Push accepted when `count < DEPTH`, or when a pop occurs in the same cycle (full with a simultaneous pop: accepted, count stays `DEPTH`).
- A rejected push sets `overflow`. It clears only on reset. The entry is lost.
- Order is strictly preserved.
- Pointers wrap modulo `DEPTH`. Count width is `clog2(DEPTH)+1`.

## Timing
- Reset values: `port7ffd=0`, `border=0`, FIFO empty, `vram_we=0`, `fifo_full=0`, `overflow=0`. Reset mid-drain discards all queued entries.
- `port7ffd` and `border` update at the edge that samples the pulse and are visible the next cycle.
- Simultaneous `cpu_mwr` and `cpu_iowr`: the memory decode uses the `port7ffd` value from before the edge.
- Push at edge N → `vram_we` high in cycle N+1 if the FIFO was empty. If `vram_busy` is low in cycle N+1, the entry is written and popped at edge N+1.
- With `vram_busy` held low, sustained throughput is one write per cycle.
- `fifo_full` and `overflow` are registered and change at the edge that alters occupancy or drops an entry.

## Structure
Shared package `ula_pkg` holds:
- Port constants: `PORT_FE` decode mask, `PORT_7FFD` decode mask.
- `P7FFD_LOCK=5`, `P7FFD_SHADOW=3`, `P7FFD_HIRES=6`.
- `SCREEN_TOP`.
- Typedef for the 22-bit FIFO entry `{bank, offset[12:0], data[7:0]}`.

Natural sub-module: `ula_wfifo`, a generic synchronous FIFO with push/pop/full/empty and simultaneous push-on-full when popping. `ula_bus` holds the decode logic and registers.

## Test plan
- After reset, IO write 0x7FFD=0x17 then 0x00FE=0x05 → `port7ffd=0x17`, `border=3'b101`. Then 0x7FFD=0x20 → 0x20; then 0x7FFD=0x07 → stays 0x20 (locked).
- Mem write 0x4000=0xAA, `vram_busy=0` → next cycle `vram_we=1`, `vram_addr=14'h0000`, `vram_data=0xAA`, high for exactly one cycle. Mem write 0x5B00 → no `vram_we`.
- `port7ffd[2:0]=7`, mem write 0xDAFF=0x3C → `vram_addr=14'h3AFF`. With `port7ffd[2:0]=5`, 0xC010 → `14'h0010`. With page 3, 0xC010 → discarded.
- `vram_busy=1`, five consecutive screen writes → `fifo_full=1` after the 4th, `overflow=1` after the 5th. Release busy → exactly 4 writes drain, in order.
- FIFO full, push and pop in the same cycle → push accepted, no overflow, all 5 values appear in order.
- Reset asserted with 3 entries queued → `vram_we=0` the next cycle and nothing is written afterwards.
